// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_pkg
// Description : Shared types, constants and helpers for the memory-access
//               pipeline stage (instruction kinds, FSM states, byte enables).
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_pkg;

    localparam int OPERAND_WIDTH             = 32;
    localparam int REGISTER_DESCRIPTOR_WIDTH = 5;

    // Decoded instruction kind; everything that is not a load/store is OTHER.
    typedef enum logic [3:0] {
        INSTR_OTHER = 4'd0,
        INSTR_LB    = 4'd1,
        INSTR_LH    = 4'd2,
        INSTR_LW    = 4'd3,
        INSTR_LBU   = 4'd4,
        INSTR_LHU   = 4'd5,
        INSTR_SB    = 4'd6,
        INSTR_SH    = 4'd7,
        INSTR_SW    = 4'd8
    } instr_kind_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    function automatic logic is_load(input instr_kind_t kind);
        return (kind == INSTR_LB)  || (kind == INSTR_LH)  || (kind == INSTR_LW) ||
               (kind == INSTR_LBU) || (kind == INSTR_LHU);
    endfunction

    function automatic logic is_store(input instr_kind_t kind);
        return (kind == INSTR_SB) || (kind == INSTR_SH) || (kind == INSTR_SW);
    endfunction

endpackage
`default_nettype wire

// File: rtl/memory_access_load_store_align.sv
`default_nettype none
// ============================================================================
// Module      : load_store_align
// Description : Combinational lane logic for 32-bit data memory accesses:
//               byte enables, store lane replication, misalignment detection
//               and load lane select with sign/zero extension.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_align
    import mem_access_pkg::*;
(
    input  instr_kind_t  req_kind,
    input  logic [1:0]   req_offset,
    input  logic [31:0]  store_data,
    output logic [3:0]   byte_enable,
    output logic [31:0]  store_lanes,
    output logic         misaligned,
    input  instr_kind_t  load_kind,
    input  logic [1:0]   load_offset,
    input  logic [31:0]  load_word,
    output logic [31:0]  load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Request side: enables and lanes follow the access size; sub-word stores
    // are replicated so the memory can pick whichever lane the enables select.
    always_comb begin
        byte_enable = BE_WORD;
        store_lanes = store_data;
        misaligned  = 1'b0;
        case (req_kind)
            INSTR_LB, INSTR_LBU, INSTR_SB: begin
                byte_enable = BE_BYTE << req_offset;
                store_lanes = {4{store_data[7:0]}};
            end
            INSTR_LH, INSTR_LHU, INSTR_SH: begin
                byte_enable = BE_HALF << req_offset;
                store_lanes = {2{store_data[15:0]}};
                misaligned  = req_offset[0];
            end
            INSTR_LW, INSTR_SW: begin
                misaligned  = |req_offset;
            end
            default: begin
                byte_enable = BE_WORD;
            end
        endcase
    end

    // Load side: pick the addressed lane, then extend to the full width.
    always_comb begin
        case (load_offset)
            2'd0:    w_byte = load_word[7:0];
            2'd1:    w_byte = load_word[15:8];
            2'd2:    w_byte = load_word[23:16];
            default: w_byte = load_word[31:24];
        endcase
        w_half = load_offset[1] ? load_word[31:16] : load_word[15:0];
        case (load_kind)
            INSTR_LB:  load_data = {{24{w_byte[7]}}, w_byte};
            INSTR_LBU: load_data = {24'd0, w_byte};
            INSTR_LH:  load_data = {{16{w_half[15]}}, w_half};
            INSTR_LHU: load_data = {16'd0, w_half};
            default:   load_data = load_word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/memory_access.sv
`default_nettype none
// ============================================================================
// Module      : memory_access
// Description : Memory-access pipeline stage. Issues loads/stores on a
//               req/gnt/rvalid bus, aligns and extends load data, and passes
//               non-memory results through with one cycle of latency.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_access
    import mem_access_pkg::*;
#(
    parameter int OPERAND_WIDTH             = mem_access_pkg::OPERAND_WIDTH,
    parameter int REGISTER_DESCRIPTOR_WIDTH = mem_access_pkg::REGISTER_DESCRIPTOR_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 valid_input,
    input  logic                                 stall_input,
    input  instr_kind_t                          instr_kind,
    input  logic [OPERAND_WIDTH-1:0]             result_input,
    input  logic [OPERAND_WIDTH-1:0]             store_data,
    input  logic [REGISTER_DESCRIPTOR_WIDTH-1:0] rd_addr_input,
    input  logic                                 write_register_input,
    output logic                                 stall_output,
    output logic                                 mem_req,
    output logic                                 mem_we,
    output logic [OPERAND_WIDTH-1:0]             mem_addr,
    output logic [3:0]                           mem_be,
    output logic [OPERAND_WIDTH-1:0]             mem_wdata,
    input  logic                                 mem_gnt,
    input  logic                                 mem_rvalid,
    input  logic [OPERAND_WIDTH-1:0]             mem_rdata,
    output logic                                 valid_output,
    output logic [OPERAND_WIDTH-1:0]             result_output,
    output logic [REGISTER_DESCRIPTOR_WIDTH-1:0] rd_addr_output,
    output logic                                 write_register,
    output logic                                 misaligned
);

    mem_state_t                           r_state;
    instr_kind_t                          r_kind;
    logic [OPERAND_WIDTH-1:0]             r_addr;
    logic [REGISTER_DESCRIPTOR_WIDTH-1:0] r_rd;

    logic                     w_hold;
    logic                     w_accept;
    logic                     w_is_mem;
    logic                     w_misaligned;
    logic [3:0]               w_be;
    logic [OPERAND_WIDTH-1:0] w_wdata;
    logic [OPERAND_WIDTH-1:0] w_load_data;

    load_store_align u_align (
        .req_kind    (instr_kind),
        .req_offset  (result_input[1:0]),
        .store_data  (store_data),
        .byte_enable (w_be),
        .store_lanes (w_wdata),
        .misaligned  (w_misaligned),
        .load_kind   (r_kind),
        .load_offset (r_addr[1:0]),
        .load_word   (mem_rdata),
        .load_data   (w_load_data)
    );

    // Output registers are frozen while writeback refuses a valid result;
    // nothing new may complete or be accepted during that time.
    always_comb begin
        w_hold       = valid_output && stall_input;
        stall_output = (r_state != IDLE) || w_hold;
        w_accept     = valid_input && !stall_output;
        w_is_mem     = is_load(instr_kind) || is_store(instr_kind);
    end

    // Bus FSM plus writeback-facing pipeline registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_kind         <= INSTR_OTHER;
            r_addr         <= '0;
            r_rd           <= '0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_be         <= 4'b0000;
            mem_wdata      <= '0;
            valid_output   <= 1'b0;
            result_output  <= '0;
            rd_addr_output <= '0;
            write_register <= 1'b0;
            misaligned     <= 1'b0;
        end else begin
            // A result that was taken is dropped unless something completes below.
            if (!w_hold) begin
                valid_output <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_is_mem && !w_misaligned) begin
                            r_state   <= REQ;
                            r_kind    <= instr_kind;
                            r_addr    <= result_input;
                            r_rd      <= rd_addr_input;
                            mem_req   <= 1'b1;
                            mem_we    <= is_store(instr_kind);
                            mem_addr  <= {result_input[OPERAND_WIDTH-1:2], 2'b00};
                            mem_be    <= w_be;
                            mem_wdata <= w_wdata;
                        end else begin
                            // Pass-through, or a faulting access reported with its address.
                            valid_output   <= 1'b1;
                            result_output  <= result_input;
                            rd_addr_output <= rd_addr_input;
                            misaligned     <= w_misaligned;
                            write_register <= !w_misaligned && write_register_input &&
                                              (rd_addr_input != '0);
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt && !w_hold) begin
                        mem_req <= 1'b0;
                        if (mem_we) begin
                            r_state        <= IDLE;
                            valid_output   <= 1'b1;
                            result_output  <= r_addr;
                            rd_addr_output <= r_rd;
                            misaligned     <= 1'b0;
                            write_register <= 1'b0;
                        end else begin
                            r_state <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (mem_rvalid && !w_hold) begin
                        r_state        <= IDLE;
                        valid_output   <= 1'b1;
                        result_output  <= w_load_data;
                        rd_addr_output <= r_rd;
                        misaligned     <= 1'b0;
                        write_register <= (r_rd != '0);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memory_access.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_access
// Description : Directed self-checking bench for memory_access.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_access;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_input;
    logic        stall_input;
    instr_kind_t instr_kind;
    logic [31:0] result_input;
    logic [31:0] store_data;
    logic [4:0]  rd_addr_input;
    logic        write_register_input;
    logic        stall_output;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        valid_output;
    logic [31:0] result_output;
    logic [4:0]  rd_addr_output;
    logic        write_register;
    logic        misaligned;

    int pass_cnt  = 0;
    int total_cnt = 0;

    memory_access dut (
        .clk                  (clk),
        .rst                  (rst),
        .valid_input          (valid_input),
        .stall_input          (stall_input),
        .instr_kind           (instr_kind),
        .result_input         (result_input),
        .store_data           (store_data),
        .rd_addr_input        (rd_addr_input),
        .write_register_input (write_register_input),
        .stall_output         (stall_output),
        .mem_req              (mem_req),
        .mem_we               (mem_we),
        .mem_addr             (mem_addr),
        .mem_be               (mem_be),
        .mem_wdata            (mem_wdata),
        .mem_gnt              (mem_gnt),
        .mem_rvalid           (mem_rvalid),
        .mem_rdata            (mem_rdata),
        .valid_output         (valid_output),
        .result_output        (result_output),
        .rd_addr_output       (rd_addr_output),
        .write_register       (write_register),
        .misaligned           (misaligned)
    );

    always #5 clk = ~clk;

    task automatic drive_idle();
        valid_input          = 1'b0;
        instr_kind           = INSTR_OTHER;
        result_input         = 32'd0;
        store_data           = 32'd0;
        rd_addr_input        = 5'd0;
        write_register_input = 1'b0;
    endtask

    task automatic issue(input instr_kind_t k, input logic [31:0] a, input logic [31:0] sd,
                         input logic [4:0] rd, input logic wr);
        valid_input          = 1'b1;
        instr_kind           = k;
        result_input         = a;
        store_data           = sd;
        rd_addr_input        = rd;
        write_register_input = wr;
    endtask

    task automatic test_reset();
        rst = 1'b0; stall_input = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        drive_idle();
        repeat (2) @(negedge clk);
        total_cnt++; if (valid_output !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_output); else pass_cnt++;
        total_cnt++; if (mem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", mem_req); else pass_cnt++;
        total_cnt++; if (stall_output !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall_output); else pass_cnt++;
        total_cnt++; if (result_output !== 32'd0) $display("FAIL reset_result: got %h want 0", result_output); else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_alu();
        issue(INSTR_OTHER, 32'h12, 32'd0, 5'd3, 1'b1);
        @(negedge clk);
        drive_idle();
        total_cnt++; if (valid_output !== 1'b1) $display("FAIL alu_valid: got %b want 1", valid_output); else pass_cnt++;
        total_cnt++; if (result_output !== 32'h12) $display("FAIL alu_result: got %h want 00000012", result_output); else pass_cnt++;
        total_cnt++; if (write_register !== 1'b1) $display("FAIL alu_wr: got %b want 1", write_register); else pass_cnt++;
        total_cnt++; if (rd_addr_output !== 5'd3) $display("FAIL alu_rd: got %0d want 3", rd_addr_output); else pass_cnt++;
        total_cnt++; if (mem_req !== 1'b0) $display("FAIL alu_req: got %b want 0", mem_req); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (valid_output !== 1'b0) $display("FAIL alu_valid_drop: got %b want 0", valid_output); else pass_cnt++;
    endtask

    task automatic test_rd_zero();
        issue(INSTR_OTHER, 32'h77, 32'd0, 5'd0, 1'b1);
        @(negedge clk);
        drive_idle();
        total_cnt++; if (write_register !== 1'b0) $display("FAIL rd0_wr: got %b want 0", write_register); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_lb();
        issue(INSTR_LB, 32'h0000_1003, 32'd0, 5'd5, 1'b0);
        @(negedge clk);
        drive_idle();
        total_cnt++; if (mem_req !== 1'b1) $display("FAIL lb_req: got %b want 1", mem_req); else pass_cnt++;
        total_cnt++; if (mem_addr !== 32'h0000_1000) $display("FAIL lb_addr: got %h want 00001000", mem_addr); else pass_cnt++;
        total_cnt++; if (mem_be !== 4'b1000) $display("FAIL lb_be: got %b want 1000", mem_be); else pass_cnt++;
        total_cnt++; if (mem_we !== 1'b0) $display("FAIL lb_we: got %b want 0", mem_we); else pass_cnt++;
        total_cnt++; if (stall_output !== 1'b1) $display("FAIL lb_stall1: got %b want 1", stall_output); else pass_cnt++;
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        total_cnt++; if (stall_output !== 1'b1) $display("FAIL lb_stall2: got %b want 1", stall_output); else pass_cnt++;
        total_cnt++; if (valid_output !== 1'b0) $display("FAIL lb_early_valid: got %b want 0", valid_output); else pass_cnt++;
        mem_rvalid = 1'b1; mem_rdata = 32'h80FF_FF00;
        @(negedge clk);
        mem_rvalid = 1'b0;
        total_cnt++; if (valid_output !== 1'b1) $display("FAIL lb_valid: got %b want 1", valid_output); else pass_cnt++;
        total_cnt++; if (result_output !== 32'hFFFF_FF80) $display("FAIL lb_result: got %h want ffffff80", result_output); else pass_cnt++;
        total_cnt++; if (write_register !== 1'b1) $display("FAIL lb_wr: got %b want 1", write_register); else pass_cnt++;
        total_cnt++; if (stall_output !== 1'b0) $display("FAIL lb_stall_end: got %b want 0", stall_output); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_sh_wait();
        issue(INSTR_SH, 32'h0000_2002, 32'hAAAA_1234, 5'd7, 1'b1);
        @(negedge clk);
        drive_idle();
        for (int i = 0; i < 3; i++) begin
            total_cnt++; if (mem_req !== 1'b1) $display("FAIL sh_req_%0d: got %b want 1", i, mem_req); else pass_cnt++;
            total_cnt++; if (mem_be !== 4'b1100) $display("FAIL sh_be_%0d: got %b want 1100", i, mem_be); else pass_cnt++;
            total_cnt++; if (mem_wdata !== 32'h1234_1234) $display("FAIL sh_wdata_%0d: got %h want 12341234", i, mem_wdata); else pass_cnt++;
            total_cnt++; if (mem_addr !== 32'h0000_2000) $display("FAIL sh_addr_%0d: got %h want 00002000", i, mem_addr); else pass_cnt++;
            @(negedge clk);
        end
        total_cnt++; if (mem_we !== 1'b1) $display("FAIL sh_we: got %b want 1", mem_we); else pass_cnt++;
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        total_cnt++; if (valid_output !== 1'b1) $display("FAIL sh_valid: got %b want 1", valid_output); else pass_cnt++;
        total_cnt++; if (write_register !== 1'b0) $display("FAIL sh_wr: got %b want 0", write_register); else pass_cnt++;
        total_cnt++; if (mem_req !== 1'b0) $display("FAIL sh_req_drop: got %b want 0", mem_req); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_sb();
        issue(INSTR_SB, 32'h0000_6001, 32'h1234_56AB, 5'd8, 1'b1);
        @(negedge clk);
        drive_idle();
        total_cnt++; if (mem_be !== 4'b0010) $display("FAIL sb_be: got %b want 0010", mem_be); else pass_cnt++;
        total_cnt++; if (mem_wdata !== 32'hABAB_ABAB) $display("FAIL sb_wdata: got %h want abababab", mem_wdata); else pass_cnt++;
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        total_cnt++; if (valid_output !== 1'b1) $display("FAIL sb_valid: got %b want 1", valid_output); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_misaligned();
        issue(INSTR_LW, 32'h0000_3001, 32'd0, 5'd9, 1'b1);
        @(negedge clk);
        drive_idle();
        total_cnt++; if (mem_req !== 1'b0) $display("FAIL mis_req: got %b want 0", mem_req); else pass_cnt++;
        total_cnt++; if (valid_output !== 1'b1) $display("FAIL mis_valid: got %b want 1", valid_output); else pass_cnt++;
        total_cnt++; if (misaligned !== 1'b1) $display("FAIL mis_flag: got %b want 1", misaligned); else pass_cnt++;
        total_cnt++; if (write_register !== 1'b0) $display("FAIL mis_wr: got %b want 0", write_register); else pass_cnt++;
        total_cnt++; if (result_output !== 32'h0000_3001) $display("FAIL mis_result: got %h want 00003001", result_output); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_lhu_stall();
        issue(INSTR_LHU, 32'h0000_4002, 32'd0, 5'd6, 1'b0);
        @(negedge clk);
        drive_idle();
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hBEEF_0000; stall_input = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;
        issue(INSTR_OTHER, 32'h55, 32'd0, 5'd2, 1'b1);
        for (int i = 0; i < 2; i++) begin
            total_cnt++; if (valid_output !== 1'b1) $display("FAIL lhu_hold_valid_%0d: got %b want 1", i, valid_output); else pass_cnt++;
            total_cnt++; if (result_output !== 32'h0000_BEEF) $display("FAIL lhu_hold_result_%0d: got %h want 0000beef", i, result_output); else pass_cnt++;
            total_cnt++; if (rd_addr_output !== 5'd6) $display("FAIL lhu_hold_rd_%0d: got %0d want 6", i, rd_addr_output); else pass_cnt++;
            total_cnt++; if (stall_output !== 1'b1) $display("FAIL lhu_hold_stall_%0d: got %b want 1", i, stall_output); else pass_cnt++;
            @(negedge clk);
        end
        stall_input = 1'b0;
        total_cnt++; if (result_output !== 32'h0000_BEEF) $display("FAIL lhu_hold_last: got %h want 0000beef", result_output); else pass_cnt++;
        @(negedge clk);
        drive_idle();
        total_cnt++; if (result_output !== 32'h55) $display("FAIL lhu_next_result: got %h want 00000055", result_output); else pass_cnt++;
        total_cnt++; if (rd_addr_output !== 5'd2) $display("FAIL lhu_next_rd: got %0d want 2", rd_addr_output); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (valid_output !== 1'b0) $display("FAIL lhu_valid_drop: got %b want 0", valid_output); else pass_cnt++;
    endtask

    task automatic test_reset_in_resp();
        issue(INSTR_LW, 32'h0000_5000, 32'd0, 5'd4, 1'b0);
        @(negedge clk);
        drive_idle();
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        total_cnt++; if (stall_output !== 1'b1) $display("FAIL rr_in_resp: got %b want 1", stall_output); else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++; if (result_output !== 32'd0) $display("FAIL rr_result: got %h want 0", result_output); else pass_cnt++;
        total_cnt++; if (rd_addr_output !== 5'd0) $display("FAIL rr_rd: got %0d want 0", rd_addr_output); else pass_cnt++;
        total_cnt++; if (stall_output !== 1'b0) $display("FAIL rr_stall: got %b want 0", stall_output); else pass_cnt++;
        total_cnt++; if (mem_addr !== 32'd0) $display("FAIL rr_addr: got %h want 0", mem_addr); else pass_cnt++;
        @(negedge clk);
        rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_rvalid = 1'b0;
        total_cnt++; if (valid_output !== 1'b0) $display("FAIL rr_stray_valid: got %b want 0", valid_output); else pass_cnt++;
        total_cnt++; if (mem_req !== 1'b0) $display("FAIL rr_stray_req: got %b want 0", mem_req); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_rd_zero();
        test_lb();
        test_sh_wait();
        test_sb();
        test_misaligned();
        test_lhu_stall();
        test_reset_in_resp();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/memory_access.md
Name: memory_access

Overview:
- Pipeline stage directly downstream of the execution stage.
- Consumes the ALU result (used as the effective address for loads and stores), store data and the destination register. Performs the data-memory transaction over a req/gnt/rvalid bus, aligns and extends load data, and hands the writeback stage a registered result.
- Non-memory instructions pass through with one cycle of latency.

Parameters:
- OPERAND_WIDTH, 32 (from register_file_params), data and address width.
- REGISTER_DESCRIPTOR_WIDTH, 5 (from register_file_params), rd index width.

Ports:
- clk  input  1  single clock
- rst  input  1  reset, asynchronous, active-low
- valid_input  input  1  execution output is valid
- stall_input  input  1  writeback cannot accept this cycle
- instr_kind  input  instr_kind_t  decoded instruction kind
- result_input  input  OPERAND_WIDTH  ALU result / effective address
- store_data  input  OPERAND_WIDTH  rs2 value for stores
- rd_addr_input  input  REGISTER_DESCRIPTOR_WIDTH  destination register
- write_register_input  input  1  execution requests register write
- stall_output  output  1  back-pressure to execution
- mem_req  output  1  bus request
- mem_we  output  1  1 = store
- mem_addr  output  OPERAND_WIDTH  word-aligned address (bits [1:0] = 0)
- mem_be  output  4  byte enables
- mem_wdata  output  OPERAND_WIDTH  lane-shifted store data
- mem_gnt  input  1  request accepted
- mem_rvalid  input  1  load data valid
- mem_rdata  input  OPERAND_WIDTH  load data word
- valid_output  output  1  result valid to writeback
- result_output  output  OPERAND_WIDTH  writeback data
- rd_addr_output  output  REGISTER_DESCRIPTOR_WIDTH  destination register
- write_register  output  1  writeback enable
- misaligned  output  1  access-fault flag, qualified by valid_output

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; every output register cleared to 0; mem_req=0. Reset during an in-flight transaction abandons it; any late gnt/rvalid after reset release is ignored in IDLE.
- Accept condition: valid_input && !stall_output, at the rising edge.
- stall_output = (state != IDLE) || (valid_output && stall_input).
- FSM states:
  - IDLE: no bus activity.
  - REQ: mem_req=1; mem_addr, mem_we, mem_be and mem_wdata are held stable until mem_gnt=1.
  - RESP: waiting for mem_rvalid.
- Transitions:
  - IDLE -> REQ on accepting an aligned load or store.
  - REQ -> RESP on gnt for a load.
  - REQ -> IDLE on gnt for a store; store output is registered that edge.
  - RESP -> IDLE on rvalid; extended load data is registered that edge.
- Non-memory kinds, and accepted misaligned accesses: registered in one cycle; result_output = result_input; no bus request.
- Latency with zero-wait memory (gnt in the REQ cycle, rvalid one cycle later): store 2 cycles accept-to-valid_output, load 3 cycles.
- rvalid is never expected in REQ; if it is seen there, it is ignored.
- Byte enables: LB/LBU/SB = 1 << addr[1:0]; LH/LHU/SH = 0011 << addr[1:0]; LW/SW = 1111.
- mem_wdata: SB = byte replicated on all 4 lanes; SH = halfword replicated on both halves; SW = unchanged.
- Load extension: select the lane by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW uses the full word.
- Misalignment:
  - Halfword access with addr[0]=1, or word access with addr[1:0]!=0, issues no bus request.
  - Output that instruction with misaligned=1, write_register=0, result_output = address.
- write_register:
  - 1 for loads (unless misaligned).
  - 0 for stores.
  - write_register_input for other kinds.
  - Always forced to 0 when rd_addr = 0.
- Output hold: while valid_output && stall_input, all output registers hold their values. valid_output clears when the output is taken and nothing new completes.
- Simultaneous completion and downstream stall: completion is deferred. gnt (REQ) and rvalid (RESP) are not honoured while output registers are held.

Decomposition:
- Package mem_access_pkg:
  - mem_state_t (IDLE, REQ, RESP).
  - Helpers is_load(instr_kind_t), is_store(instr_kind_t).
  - Constants BE_BYTE=4'b0001, BE_HALF=4'b0011, BE_WORD=4'b1111.
- Sub-module load_store_align: purely combinational. Produces byte enables, the store lane shift, load lane select with extension, and the misaligned flag from kind and addr[1:0]. The FSM and pipeline registers stay in memory_access.

Test Plan:
- ADD, result_input=0x12, rd=3, no stall -> valid_output next cycle; result_output=0x12; write_register=1; mem_req never asserted.
- LB at addr 0x1003, mem_rdata=0x80FF_FF00, zero-wait memory -> mem_addr=0x1000, mem_be=1000; result_output=0xFFFF_FF80 three cycles after accept; stall_output high for two cycles.
- SH at addr 0x2002, store_data=0xAAAA_1234, gnt delayed 3 cycles -> mem_req, mem_be=1100 and mem_wdata=0x1234_1234 held stable through the wait; write_register=0.
- LW at addr 0x3001 -> no mem_req; misaligned=1; write_register=0; result_output=0x3001.
- LHU completes while stall_input=1 for 2 cycles -> output held unchanged and the next instruction is stalled. After release: result_output=zero-extended halfword, valid for exactly one transfer.
- rst driven low while in RESP -> all outputs 0 immediately. A stray rvalid after reset release does not produce valid_output.
